buzzer_song_player: RTL and testbench
=====================================

BUZZER_SONG_PLAYER -- requirements
Module: buzzer_song_player

Interface
REQ-001 SHALL have parameter NOTE_CYCLES, default 25_000_000, clock cycles per note (250 ms at 100 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 2_500_000, silent cycles after each note; legal range 1 to NOTE_CYCLES-1.
REQ-003 SHALL have parameter TONE_SHIFT, default 0, right-shift applied to every tone half-period (simulation speed-up).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-006 SHALL have port i_play, input, 1 bit, level "wash done" from the washing-machine controller; a rising edge starts a song.
REQ-007 SHALL have port i_song_sel, input, 1 bit, song select: 0 = song A, 1 = song B.
REQ-008 SHALL have port i_stop, input, 1 bit, abort playback.
REQ-009 SHALL have port o_buzzer, output, 1 bit, square-wave buzzer drive.
REQ-010 SHALL have port o_busy, output, 1 bit, high while a song is playing.
REQ-011 SHALL have port o_done, output, 1 bit, one-cycle pulse when a song ends normally.

Function
REQ-012 SHALL use a state machine with states IDLE, NOTE, GAP and FINISH.
REQ-013 In IDLE, the cycle after an i_play rising edge (registered previous value 0, current value 1) SHALL latch i_song_sel, set note index 0, enter NOTE and set o_busy=1.
REQ-014 Each song SHALL be 16 four-bit note codes: 0 = rest, 1-7 = C4-B4, 8-14 = C5-B5, 15 = rest.
REQ-015 In NOTE, a divider SHALL count 0..(HALF[code]>>TONE_SHIFT)-1; at the terminal count it SHALL reset to 0 and toggle o_buzzer.
REQ-016 For a rest code, o_buzzer SHALL be held at 0.
REQ-017 NOTE SHALL last exactly NOTE_CYCLES cycles, then enter GAP with o_buzzer=0.
REQ-018 GAP SHALL last exactly GAP_CYCLES cycles; on exit the note index SHALL increment and the divider SHALL restart from 0 with o_buzzer=0.
REQ-019 Leaving GAP after note index 15 SHALL enter FINISH.
REQ-020 FINISH SHALL last one cycle: o_done=1, o_busy=0, then IDLE.
REQ-021 An i_play edge while not in IDLE SHALL be ignored, and i_song_sel changes mid-song SHALL be ignored.
REQ-022 i_stop in NOTE or GAP SHALL, on the next edge, enter IDLE with o_buzzer=0, o_busy=0 and no o_done pulse.
REQ-023 i_stop SHALL win over a simultaneous i_play edge, and IDLE SHALL stay IDLE.
REQ-024 i_play held high after the song ends SHALL NOT restart the song; a new 0-to-1 transition is required.
REQ-025 A shifted half-period of 0 SHALL be treated as 1.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL go to IDLE with o_buzzer=0, o_busy=0, o_done=0, all counters 0 and the edge-detect register 0.
REQ-027 Reset mid-song SHALL abort the song with no o_done pulse.

Configuration
REQ-028 With macro SONG_LOOP_EN defined, leaving GAP after index 15 SHALL wrap to index 0 and continue until i_stop or rst, and FINISH and o_done SHALL never occur.
REQ-029 With SONG_LOOP_EN undefined, behaviour SHALL be per REQ-019 and REQ-020.

Structure
REQ-030 A shared package song_pkg SHALL hold: the state enum; the note-code width (4); the HALF[0:15] half-period table at 100 MHz (C4 = 191113 ... B5 = 50619, rests 0); and the SONG_A and SONG_B ROM constants.
REQ-031 One sub-module, tone_gen, SHALL contain the divider and toggle flop (inputs clk, rst, enable, half_period; output wave).
REQ-032 The top level SHALL hold the state machine, edge detect and the note and duration counters.

Verification
Bench parameters: NOTE_CYCLES=2000, GAP_CYCLES=20, TONE_SHIFT=10.
REQ-033 Drive rst=1 for 3 cycles -> o_buzzer, o_busy and o_done all 0; no o_buzzer toggles while in IDLE.
REQ-034 i_song_sel=0, then raise i_play -> o_busy=1 the next cycle; the first note (C4) toggles o_buzzer every 186 cycles; o_done pulses once, exactly 16*2020+1 cycles after start.
REQ-035 i_song_sel=1 at start, flipped to 0 mid-song -> the full song B sequence plays unchanged, checked as toggle periods per note against the table.
REQ-036 i_stop asserted during note 5 -> o_busy=0 and o_buzzer=0 the next cycle; no o_done pulse; a new i_play edge restarts from note 0.
REQ-037 rst asserted during a GAP -> IDLE the next cycle; i_play held high through reset release does not start a song until it toggles low then high.
REQ-038 With SONG_LOOP_EN defined -> the note index wraps 15 to 0 with no o_done pulse across 2 full passes.

Source files
------------

// File: rtl/song_pkg.sv
// Shared types and tables for the buzzer song player: FSM states, note-code width,
// tone half-period table (100 MHz clock) and the two song ROMs.
package song_pkg;

  localparam int NOTE_W = 4;
  localparam int HALF_W = 18;

  typedef enum logic [1:0] {
    IDLE,
    NOTE,
    GAP,
    FINISH
  } state_t;

  // Half-period in clock cycles for each note code; codes 0 and 15 are rests
  localparam logic [HALF_W-1:0] HALF [16] = '{
    18'd0,
    18'd191113, 18'd170265, 18'd151686, 18'd143173, 18'd127551, 18'd113636, 18'd101239,
    18'd95557,  18'd85131,  18'd75843,  18'd71586,  18'd63776,  18'd56818,  18'd50619,
    18'd0
  };

  localparam logic [NOTE_W-1:0] SONG_A [16] = '{
    4'd1, 4'd1, 4'd5, 4'd5, 4'd6, 4'd6, 4'd5, 4'd0,
    4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd15
  };

  localparam logic [NOTE_W-1:0] SONG_B [16] = '{
    4'd8,  4'd10, 4'd12, 4'd8,  4'd12, 4'd14, 4'd13, 4'd0,
    4'd9,  4'd11, 4'd13, 4'd9,  4'd14, 4'd12, 4'd10, 4'd15
  };

  function automatic logic is_rest(input logic [NOTE_W-1:0] code);
    return (code == 4'd0) || (code == 4'd15);
  endfunction

  // A shift that collapses the half-period to zero is clamped to one cycle
  function automatic logic [HALF_W-1:0] shifted_half(input logic [NOTE_W-1:0] code,
                                                     input int shift);
    logic [HALF_W-1:0] hp;
    hp = HALF[code] >> shift;
    return (hp == '0) ? HALF_W'(1) : hp;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator: divider counts 0..half_period-1 and toggles the output
// at terminal count; held in reset (counter 0, wave 0) whenever enable is low.
module tone_gen
  import song_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [HALF_W-1:0] half_period,
  output logic              wave
);

  logic [HALF_W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      div_cnt <= '0;
      wave    <= 1'b0;
    end else if (div_cnt == half_period - HALF_W'(1)) begin
      div_cnt <= '0;
      wave    <= ~wave;
    end else begin
      div_cnt <= div_cnt + HALF_W'(1);
    end
  end

endmodule

// File: rtl/buzzer_song_player.sv
// Plays one of two 16-note songs on a buzzer when i_play rises.
// Define SONG_LOOP_EN to repeat the song until i_stop or rst instead of finishing.
module buzzer_song_player
  import song_pkg::*;
#(
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int TONE_SHIFT  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_play,
  input  logic i_song_sel,
  input  logic i_stop,
  output logic o_buzzer,
  output logic o_busy,
  output logic o_done
);

  localparam int DUR_W = $clog2(NOTE_CYCLES + 1);
  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_CYCLES - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_CYCLES - 1);

  state_t            state;
  logic [3:0]        note_idx;
  logic              song_sel;
  logic [DUR_W-1:0]  dur_cnt;
  logic              play_p1;
  logic              play_armed;

  logic [NOTE_W-1:0] code;
  logic [HALF_W-1:0] half_period;
  logic              play_rise;
  logic              note_last;
  logic              tone_en;

  // play_armed blocks a start until i_play has been seen low after reset
  always_comb begin
    code        = song_sel ? SONG_B[note_idx] : SONG_A[note_idx];
    half_period = shifted_half(code, TONE_SHIFT);
    play_rise   = i_play && !play_p1 && play_armed;
    note_last   = (state == NOTE) && (dur_cnt == NOTE_LAST);
    tone_en     = (state == NOTE) && !i_stop && !note_last && !is_rest(code);
  end

  tone_gen u_tone_gen (
    .clk         (clk),
    .rst         (rst),
    .enable      (tone_en),
    .half_period (half_period),
    .wave        (o_buzzer)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      note_idx   <= '0;
      song_sel   <= 1'b0;
      dur_cnt    <= '0;
      play_p1    <= 1'b0;
      play_armed <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      play_p1 <= i_play;
      if (!i_play) play_armed <= 1'b1;
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (play_rise && !i_stop) begin
            song_sel <= i_song_sel;
            note_idx <= '0;
            dur_cnt  <= '0;
            state    <= NOTE;
            o_busy   <= 1'b1;
          end
        end
        NOTE: begin
          if (i_stop) begin
            state   <= IDLE;
            dur_cnt <= '0;
            o_busy  <= 1'b0;
          end else if (dur_cnt == NOTE_LAST) begin
            dur_cnt <= '0;
            state   <= GAP;
          end else begin
            dur_cnt <= dur_cnt + DUR_W'(1);
          end
        end
        GAP: begin
          if (i_stop) begin
            state   <= IDLE;
            dur_cnt <= '0;
            o_busy  <= 1'b0;
          end else if (dur_cnt == GAP_LAST) begin
            dur_cnt <= '0;
`ifdef SONG_LOOP_EN
            note_idx <= note_idx + 4'd1;
            state    <= NOTE;
`else
            if (note_idx == 4'd15) begin
              state  <= FINISH;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              note_idx <= note_idx + 4'd1;
              state    <= NOTE;
            end
`endif
          end else begin
            dur_cnt <= dur_cnt + DUR_W'(1);
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buzzer_song_player.sv
// Scoreboard bench for buzzer_song_player: a note-level model predicts every buzzer
// transition and o_done pulse; a negedge monitor pops and compares them.
module tb_buzzer_song_player;

  localparam int NOTE   = 2000;
  localparam int GAP    = 20;
  localparam int PERIOD = NOTE + GAP;
  localparam int SHIFT  = 10;
  localparam int BIG    = 32'h7fff_ffff;
`ifdef SONG_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_play = 1'b0;
  logic i_song_sel = 1'b0;
  logic i_stop = 1'b0;
  logic o_buzzer, o_busy, o_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit prev_buz = 1'b0;

  typedef struct {
    int cyc;
    bit val;
  } ev_t;
  ev_t buz_q[$];
  int  done_q[$];

  int HALF_TB [16] = '{0, 191113, 170265, 151686, 143173, 127551, 113636, 101239,
                       95557, 85131, 75843, 71586, 63776, 56818, 50619, 0};
  bit [3:0] SONG_A_TB [16] = '{1, 1, 5, 5, 6, 6, 5, 0, 4, 4, 3, 3, 2, 2, 1, 15};
  bit [3:0] SONG_B_TB [16] = '{8, 10, 12, 8, 12, 14, 13, 0, 9, 11, 13, 9, 14, 12, 10, 15};

  buzzer_song_player #(
    .NOTE_CYCLES (NOTE),
    .GAP_CYCLES  (GAP),
    .TONE_SHIFT  (SHIFT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_play     (i_play),
    .i_song_sel (i_song_sel),
    .i_stop     (i_stop),
    .o_buzzer   (o_buzzer),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Song playing from edge e0, cut short at edge cut (stop/reset), as note-level events
  function automatic void model_song(input int e0, input bit sel, input int cut);
    int ns, hp, t, lim;
    bit v;
    bit [3:0] code;
    for (int k = 0; k < 64; k++) begin
      if (!LOOP && k == 16) begin
        if (cut > e0 + 16 * PERIOD) done_q.push_back(e0 + 16 * PERIOD);
        break;
      end
      ns = e0 + k * PERIOD;
      if (ns >= cut) break;
      code = sel ? SONG_B_TB[k % 16] : SONG_A_TB[k % 16];
      if (code == 4'd0 || code == 4'd15) continue;
      hp = HALF_TB[code] >> SHIFT;
      if (hp == 0) hp = 1;
      v = 1'b0;
      for (t = hp; t < NOTE && ns + t < cut; t += hp) begin
        v = !v;
        buz_q.push_back('{ns + t, v});
      end
      if (v) begin
        lim = ns + NOTE;
        if (cut < lim) lim = cut;
        buz_q.push_back('{lim, 1'b0});
      end
    end
  endfunction

  always @(negedge clk) begin
    ev_t ev;
    int  dc;
    if (mon_en) begin
      if (o_buzzer !== prev_buz) begin
        if (buz_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL buzzer_unexpected: changed to %0b at cycle %0d, expected no change",
                   o_buzzer, cyc);
        end else begin
          ev = buz_q.pop_front();
          chk("buzzer_edge_cycle", cyc, ev.cyc);
          chk("buzzer_edge_value", int'(o_buzzer), int'(ev.val));
        end
        prev_buz = o_buzzer;
      end
      if (o_done) begin
        if (done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected: pulse at cycle %0d, expected none", cyc);
        end else begin
          dc = done_q.pop_front();
          chk("done_cycle", cyc, dc);
        end
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Raise i_play at the current negedge; returns the edge at which the song starts
  task automatic play_edge(input bit sel, output int e0, output int tstart);
    i_song_sel = sel;
    i_play     = 1'b1;
    tstart     = cyc;
    e0         = cyc + 1;
  endtask

  task automatic stop_at(input int s);
    wait_until(s - 1);
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    chk("stop_busy", int'(o_busy), 0);
    chk("stop_buzzer", int'(o_buzzer), 0);
  endtask

  initial begin
    int e0, ts, cut, r;
    bit sel;

    repeat (3) @(negedge clk);
    chk("reset_buzzer", int'(o_buzzer), 0);
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_done", int'(o_done), 0);
    rst = 1'b0;
    prev_buz = 1'b0;
    mon_en = 1'b1;
    repeat ($urandom_range(2, 10)) @(negedge clk);

`ifdef SONG_LOOP_EN
    play_edge(1'b0, e0, ts);
    cut = e0 + 2 * 16 * PERIOD + $urandom_range(100, 2000);
    model_song(e0, 1'b0, cut);
    @(negedge clk);
    chk("loop_start_busy", int'(o_busy), 1);
    i_play = 1'b0;
    wait_until(e0 + 16 * PERIOD + 5);
    chk("loop_wrap_busy", int'(o_busy), 1);
    stop_at(cut);
`else
    // Song A, i_play held high afterwards
    play_edge(1'b0, e0, ts);
    model_song(e0, 1'b0, BIG);
    @(negedge clk);
    chk("songA_start_busy", int'(o_busy), 1);
    wait_until(ts + 16 * PERIOD + 1);
    chk("songA_done_pulse", int'(o_done), 1);
    chk("songA_finish_busy", int'(o_busy), 0);
    repeat (50) @(negedge clk);
    chk("play_held_no_restart", int'(o_busy), 0);
    i_play = 1'b0;

    // Song B with select flip and an extra i_play edge mid-song
    repeat (3) @(negedge clk);
    play_edge(1'b1, e0, ts);
    model_song(e0, 1'b1, BIG);
    @(negedge clk);
    chk("songB_start_busy", int'(o_busy), 1);
    repeat ($urandom_range(1000, 15000)) @(negedge clk);
    i_song_sel = 1'b0;
    i_play = 1'b0;
    repeat (3) @(negedge clk);
    i_play = 1'b1;
    wait_until(ts + 16 * PERIOD + 1);
    chk("songB_finish_busy", int'(o_busy), 0);
    i_play = 1'b0;
`endif

    // Stop during note 5, stop-over-play in IDLE, then restart from note 0
    repeat (3) @(negedge clk);
    play_edge(1'b0, e0, ts);
    cut = e0 + 5 * PERIOD + $urandom_range(1, 1999);
    model_song(e0, 1'b0, cut);
    repeat (2) @(negedge clk);
    i_play = 1'b0;
    stop_at(cut);
    repeat (5) @(negedge clk);
    i_play = 1'b1;
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    chk("stop_wins_busy", int'(o_busy), 0);
    repeat (3) @(negedge clk);
    chk("stop_wins_stays_idle", int'(o_busy), 0);
    i_play = 1'b0;
    repeat (2) @(negedge clk);
    play_edge(1'b0, e0, ts);
    cut = e0 + $urandom_range(300, 2500);
    model_song(e0, 1'b0, cut);
    @(negedge clk);
    chk("restart_busy", int'(o_busy), 1);
    i_play = 1'b0;
    stop_at(cut);

    // Reset during the gap after note 1, with i_play held high through release
    repeat (3) @(negedge clk);
    sel = 1'($urandom_range(0, 1));
    play_edge(sel, e0, ts);
    r = e0 + PERIOD + NOTE + $urandom_range(1, 19);
    model_song(e0, sel, r);
    wait_until(r - 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_gap_busy", int'(o_busy), 0);
    chk("rst_gap_buzzer", int'(o_buzzer), 0);
    chk("rst_gap_done", int'(o_done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_play_held_idle", int'(o_busy), 0);
    i_play = 1'b0;
    repeat (2) @(negedge clk);
    sel = 1'($urandom_range(0, 1));
    play_edge(sel, e0, ts);
    cut = e0 + $urandom_range(300, 2500);
    model_song(e0, sel, cut);
    @(negedge clk);
    chk("rst_restart_busy", int'(o_busy), 1);
    i_play = 1'b0;
    stop_at(cut);

    repeat (100) @(negedge clk);
    chk("buzzer_events_left", buz_q.size(), 0);
    chk("done_events_left", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
